// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and the per-stage pipeline record for pipelined_adder.
// Latency/backpressure: none (types and constants only).
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Record at default width; the top re-declares this shape for its own WIDTH.
    typedef struct packed {
        logic                     vld;
        logic                     carry;
        logic [DEFAULT_WIDTH-1:0] psum;
        logic [DEFAULT_WIDTH-1:0] a_rem;
        logic [DEFAULT_WIDTH-1:0] b_rem;
    } stage_rec_t;

endpackage

// File: rtl/pipelined_adder_stage.sv
// adder_stage: one registered SLICE-bit ripple slice; 1 cycle latency, holds all state while i_advance is low.
// Operands travel with the partial sum so later stages see their own slices.
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_WIDTH / DEFAULT_STAGES,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_vld,
    input  logic             i_carry,
    input  logic [WIDTH-1:0] i_psum,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_vld,
    output logic             o_carry,
    output logic [WIDTH-1:0] o_psum,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam int LO = IDX * SLICE;

    logic [SLICE:0]   w_slice_sum;
    logic [WIDTH-1:0] w_psum_nxt;

    logic             r_vld;
    logic             r_carry;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    always_comb begin
        w_slice_sum = {1'b0, i_a[LO +: SLICE]} + {1'b0, i_b[LO +: SLICE]}
                    + {{SLICE{1'b0}}, i_carry};
        w_psum_nxt  = i_psum;
        w_psum_nxt[LO +: SLICE] = w_slice_sum[SLICE-1:0];
    end

    // Data registers only load real entries; bubbles just clear the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (i_advance) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_carry <= w_slice_sum[SLICE];
                r_psum  <= w_psum_nxt;
                r_a     <= i_a;
                r_b     <= i_b;
            end
        end
    end

    assign o_vld   = r_vld;
    assign o_carry = r_carry;
    assign o_psum  = r_psum;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

// File: rtl/pipelined_adder.sv
// Skewed STAGES-deep adder, latency STAGES, one result/cycle; global stall when out_valid && !out_ready.
// Optional signed-overflow output ovf when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int SLICE = WIDTH / STAGES;

    typedef struct packed {
        logic             vld;
        logic             carry;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    // Element k feeds stage k; element STAGES is the retiring result.
    stage_t w_stg [0:STAGES];
    logic   w_advance;

    assign w_stg[0] = {in_valid, cin, {WIDTH{1'b0}}, a, b};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_advance (w_advance),
            .i_vld     (w_stg[k].vld),
            .i_carry   (w_stg[k].carry),
            .i_psum    (w_stg[k].psum),
            .i_a       (w_stg[k].a_rem),
            .i_b       (w_stg[k].b_rem),
            .o_vld     (w_stg[k+1].vld),
            .o_carry   (w_stg[k+1].carry),
            .o_psum    (w_stg[k+1].psum),
            .o_a       (w_stg[k+1].a_rem),
            .o_b       (w_stg[k+1].b_rem)
        );
    end

    assign out_valid = w_stg[STAGES].vld;
    assign sum       = w_stg[STAGES].psum;
    assign cout      = w_stg[STAGES].carry;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

`ifdef PIPELINED_ADDER_OVF_EN
    // Operand sign bits ride with the result, so ovf is as stable as sum.
    assign ovf = (w_stg[STAGES].a_rem[WIDTH-1] == w_stg[STAGES].b_rem[WIDTH-1])
              && (sum[WIDTH-1] != w_stg[STAGES].a_rem[WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized bench for pipelined_adder with an arithmetic reference model and result scoreboard.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [W+1:0] q [$];

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        longint u;
        longint s;
        longint smax;
        logic   v;
        u    = longint'(x) + longint'(y) + longint'(c);
        s    = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        smax = (longint'(1) << (W - 1)) - 1;
        v    = (s > smax) || (s < -smax - 1);
        return {v, u[W:0]};
    endfunction

    // Called just after a falling edge: score this cycle's transfers, then advance one cycle.
    task automatic tick();
        logic [W+1:0] exp;
        #1;
        if (out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_output got=%h required=no_output", sum);
            end else begin
                exp = q.pop_front();
`ifdef PIPELINED_ADDER_OVF_EN
                if ({ovf, cout, sum} !== exp) begin
                    n_err++;
                    $display("FAIL result got={ovf,cout,sum}=%h required=%h", {ovf, cout, sum}, exp);
                end
`else
                if ({cout, sum} !== exp[W:0]) begin
                    n_err++;
                    $display("FAIL result got={cout,sum}=%h required=%h", {cout, sum}, exp[W:0]);
                end
`endif
            end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, cin));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64 && q.size() != 0; i++) tick();
        n_vec++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain pending=%0d out_valid=%b required=0/0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, 1'b0, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_state got vld=%b rdy=%b cout=%b sum=%h required 0 1 0 0",
                     out_valid, in_ready, cout, sum);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf got=%b required=0", ovf);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got=%b required=1", in_ready);
        end
    endtask

    task automatic test_corner();
        int lat;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== S || {cout, sum} !== {1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL corner_ffff latency=%0d cout=%b sum=%h required %0d 1 0000", lat, cout, sum, S);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL corner_single_pulse out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_stream();
        logic         ev;
        logic [W-1:0] es;
        for (int c = 0; c < 16 + S + 2; c++) begin
            if (c < 16) begin
                a = W'(c); b = W'(2 * c); cin = 1'((c & 1)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            ev = (c >= S) && (c < S + 16);
            es = W'(3 * (c - S) + ((c - S) & 1));
            n_vec++;
            if (out_valid !== ev || (ev && sum !== es)) begin
                n_err++;
                $display("FAIL stream cycle=%0d vld=%b sum=%h required vld=%b sum=%h",
                         c, out_valid, sum, ev, es);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_stall();
        logic [W:0] held;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        #1;
        held = {cout, sum};
        for (int k = 0; k < 5; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, sum} !== held) begin
                n_err++;
                $display("FAIL stall k=%0d rdy=%b vld=%b out=%h required 0 1 %h",
                         k, in_ready, out_valid, {cout, sum}, held);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (c % 50 == 0) begin a = 16'h8000; b = 16'h8000; end
            #1;
            n_vec++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_err++;
                $display("FAIL in_ready cycle=%0d got=%b required=%b", c, in_ready, !out_valid || out_ready);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL midflight_reset vld=%b rdy=%b sum=%h required 0 1 0000", out_valid, in_ready, sum);
        end
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h1234; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== S || sum !== 16'h1235 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_first latency=%0d sum=%h cout=%b required %0d 1235 0", lat, sum, cout, S);
        end
        drain();
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W+1:0] te [2];
        int           lat;
        ta[0] = 16'h7FFF; tb[0] = 16'h0001; te[0] = {1'b1, 1'b0, 16'h8000};
        ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; te[1] = {1'b0, 1'b1, 16'hFFFE};
        for (int i = 0; i < 2; i++) begin
            a = ta[i]; b = tb[i]; cin = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
            end
            n_vec++;
            if ({ovf, cout, sum} !== te[i]) begin
                n_err++;
                $display("FAIL ovf_vec%0d got={ovf,cout,sum}=%h required=%h", i, {ovf, cout, sum}, te[i]);
            end
            tick();
        end
        drain();
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        test_reset();
        test_corner();
        test_stream();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
`ifdef PIPELINED_ADDER_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
